// File: rtl/resampler_output_sequencer.sv
// resampler_output_sequencer
// Frame-rate controller for resampler_core. Each output-frame tick issues a
// one-cycle pop to every enabled channel, gathers the acked 24-bit results
// into staging registers, and commits the whole frame in parallel when all
// enabled channels have answered, when the wait times out, or when the next
// tick arrives. Channels that miss the frame are flagged in underrun_o.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   tick_i          one-cycle strobe marking the start of an output frame
//   ch_en_i         per-channel enable, sampled when a frame starts
//   pop_o           per-channel pop pulse to the resampler
//   ack_i, data_i   resampler acknowledge (one-hot) and its 24-bit result
//   frame_data_o    committed frame, channel k at [24k +: 24]
//   frame_valid_o   one-cycle pulse when frame_data_o/underrun_o update
//   underrun_o      enabled channels that were not acked in the last frame
//   busy_o          high while a frame is in flight (ISSUE/WAIT/COMMIT)
//
// Build option: RESAMPLER_SEQ_MUTE_ON_UNDERRUN_EN
//   defined   - an underrun channel is committed as zero
//   undefined - an underrun channel holds its previous committed value

module resampler_output_sequencer #(
    parameter int unsigned NUM_CH       = 8,
    parameter int unsigned NUM_CH_LOG2  = 3,
    parameter int unsigned TIMEOUT      = 1024,
    parameter int unsigned TIMEOUT_LOG2 = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick_i,
    input  logic [NUM_CH-1:0]      ch_en_i,
    output logic [NUM_CH-1:0]      pop_o,
    input  logic [NUM_CH-1:0]      ack_i,
    input  logic [23:0]            data_i,
    output logic [NUM_CH*24-1:0]   frame_data_o,
    output logic                   frame_valid_o,
    output logic [NUM_CH-1:0]      underrun_o,
    output logic                   busy_o
);

    if ((1 << NUM_CH_LOG2) < NUM_CH) begin : g_bad_ch_log2
        $error("NUM_CH_LOG2 is too small for NUM_CH");
    end

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_COMMIT = 2'd3;

    localparam logic [TIMEOUT_LOG2:0] CNT_LAST = (TIMEOUT_LOG2 + 1)'(TIMEOUT - 1);

    logic [1:0]              state;
    logic [NUM_CH-1:0]       en_ff;
    logic [NUM_CH-1:0]       outstanding;
    logic [NUM_CH-1:0]       out_next;
    logic [TIMEOUT_LOG2:0]   cnt;
    logic                    pending_tick;
    logic [NUM_CH*24-1:0]    staging;
    logic [NUM_CH*24-1:0]    staging_next;
    logic [NUM_CH*24-1:0]    commit_data;
    logic                    wait_exit;

    assign busy_o = (state != S_IDLE);

    // This cycle's acks are folded in before the exit decision so that the
    // final ack commits on the very next edge.
    always_comb begin
        out_next     = outstanding & ~ack_i;
        staging_next = staging;
        commit_data  = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (ack_i[k] && outstanding[k]) begin
                staging_next[24*k +: 24] = data_i;
            end
        end
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (!en_ff[k]) begin
                commit_data[24*k +: 24] = '0;
            end else if (out_next[k]) begin
`ifdef RESAMPLER_SEQ_MUTE_ON_UNDERRUN_EN
                commit_data[24*k +: 24] = '0;
`else
                commit_data[24*k +: 24] = frame_data_o[24*k +: 24];
`endif
            end else begin
                commit_data[24*k +: 24] = staging_next[24*k +: 24];
            end
        end
        wait_exit = (out_next == '0) || (cnt == CNT_LAST) || tick_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            en_ff         <= '0;
            outstanding   <= '0;
            cnt           <= '0;
            pending_tick  <= 1'b0;
            staging       <= '0;
            pop_o         <= '0;
            frame_data_o  <= '0;
            frame_valid_o <= 1'b0;
            underrun_o    <= '0;
        end else begin
            pop_o         <= '0;
            frame_valid_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (tick_i) begin
                        state <= S_ISSUE;
                        en_ff <= ch_en_i;
                        pop_o <= ch_en_i;
                    end
                end
                S_ISSUE: begin
                    outstanding <= en_ff;
                    cnt         <= '0;
                    state       <= S_WAIT;
                    if (tick_i) pending_tick <= 1'b1;
                end
                S_WAIT: begin
                    cnt         <= cnt + 1'b1;
                    outstanding <= out_next;
                    staging     <= staging_next;
                    if (tick_i) pending_tick <= 1'b1;
                    // Outputs are loaded on entry to COMMIT so the pulse and
                    // the new frame appear together in the COMMIT cycle.
                    if (wait_exit) begin
                        state         <= S_COMMIT;
                        frame_valid_o <= 1'b1;
                        frame_data_o  <= commit_data;
                        underrun_o    <= out_next;
                        outstanding   <= '0;
                    end
                end
                S_COMMIT: begin
                    if (pending_tick || tick_i) begin
                        state        <= S_ISSUE;
                        en_ff        <= ch_en_i;
                        pop_o        <= ch_en_i;
                        pending_tick <= 1'b0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_resampler_output_sequencer.sv
// Testbench for resampler_output_sequencer: table-driven frames plus
// hand-written multi-cycle corner sequences, checked against a scoreboard of
// expected committed frames (data, underrun mask, commit cycle).

module tb_resampler_output_sequencer;

    localparam int unsigned NCH = 8;
    localparam int unsigned TO  = 1024;

    logic           clk = 1'b0;
    logic           rst;
    logic           tick_i;
    logic [7:0]     ch_en_i;
    logic [7:0]     pop_o;
    logic [7:0]     ack_i;
    logic [23:0]    data_i;
    logic [191:0]   frame_data_o;
    logic           frame_valid_o;
    logic [7:0]     underrun_o;
    logic           busy_o;

    resampler_output_sequencer #(
        .NUM_CH(NCH), .NUM_CH_LOG2(3), .TIMEOUT(TO), .TIMEOUT_LOG2(10)
    ) dut (
        .clk(clk), .rst(rst), .tick_i(tick_i), .ch_en_i(ch_en_i),
        .pop_o(pop_o), .ack_i(ack_i), .data_i(data_i),
        .frame_data_o(frame_data_o), .frame_valid_o(frame_valid_o),
        .underrun_o(underrun_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [191:0] data;
        logic [7:0]   underrun;
        int unsigned  cyc;
    } exp_t;

    typedef struct {
        logic [7:0]   en;
        logic [7:0]   ack;
        logic [7:0]   spur;
        logic [191:0] data;
    } vec_t;

    exp_t         sb[$];
    logic [191:0] prev_frame = '0;
    int unsigned  n_checks = 0;
    int unsigned  n_fail = 0;
    vec_t         tbl[6];
    vec_t         vclean;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Expected frame: acked -> new data, disabled -> 0, underrun -> mute/hold.
    task automatic push_exp(input logic [7:0] en, input logic [7:0] acked,
                            input logic [191:0] d, input int unsigned at);
        exp_t e;
        logic [7:0] ur;
        ur = en & ~acked;
        for (int k = 0; k < 8; k++) begin
            if (!en[k]) e.data[24*k +: 24] = '0;
            else if (ur[k]) begin
`ifdef RESAMPLER_SEQ_MUTE_ON_UNDERRUN_EN
                e.data[24*k +: 24] = '0;
`else
                e.data[24*k +: 24] = prev_frame[24*k +: 24];
`endif
            end else e.data[24*k +: 24] = d[24*k +: 24];
        end
        e.underrun = ur;
        e.cyc      = at;
        prev_frame = e.data;
        sb.push_back(e);
    endtask

    task automatic commit_now(input string name);
        exp_t e;
        check({name, " frame_valid_o"}, 192'(frame_valid_o), 192'(1));
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s scoreboard: got 0 queued frames, expected at least 1", name);
        end else begin
            e = sb.pop_front();
            if (frame_valid_o) begin
                check({name, " frame_data_o"}, frame_data_o, e.data);
                check({name, " underrun_o"}, 192'(underrun_o), 192'(e.underrun));
                check({name, " commit cycle"}, 192'(cyc), 192'(e.cyc));
            end
        end
    endtask

    task automatic wait_commit(input string name, input int unsigned budget);
        for (int unsigned i = 0; i < budget && !frame_valid_o; i++) @(negedge clk);
        commit_now(name);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int unsigned issue_c, exp_c, sp;
        logic [7:0]  acked;
        // acks while idle must be ignored
        ack_i = 8'hFF; data_i = 24'hBADBAD;
        @(negedge clk);
        ack_i = '0; data_i = '0;
        issue_c = cyc + 1;
        acked   = v.ack & v.en;
        sp      = (v.spur != '0) ? 1 : 0;
        if (acked != v.en)  exp_c = issue_c + TO + 1;
        else if (v.en == 0) exp_c = issue_c + 2;
        else                exp_c = issue_c + sp + $countones(v.ack) + 1;
        push_exp(v.en, acked, v.data, exp_c);
        tick_i = 1'b1; ch_en_i = v.en;
        @(negedge clk);
        tick_i = 1'b0;
        check({name, " pop_o"}, 192'(pop_o), 192'(v.en));
        check({name, " busy_o"}, 192'(busy_o), 192'(1));
        @(negedge clk);
        if (sp != 0) begin
            ack_i = v.spur; data_i = 24'hDEAD01;
            @(negedge clk);
        end
        for (int k = 0; k < 8; k++) begin
            if (v.ack[k]) begin
                ack_i = 8'(1 << k); data_i = v.data[24*k +: 24];
                @(negedge clk);
            end
        end
        ack_i = '0; data_i = '0;
        wait_commit(name, TO + 16);
    endtask

    initial begin
        int unsigned  ic;
        logic [191:0] d;

        rst = 1'b1; tick_i = 1'b0; ch_en_i = '0; ack_i = '0; data_i = '0;

        for (int i = 0; i < 6; i++) begin
            tbl[i].data = '0; tbl[i].spur = '0;
        end
        tbl[0].en = 8'hFF; tbl[0].ack = 8'hFF;
        for (int k = 0; k < 8; k++) tbl[0].data[24*k +: 24] = 24'(256 * (k + 1));
        tbl[1].en = 8'h03; tbl[1].ack = 8'h01;
        tbl[1].data[23:0] = 24'h00AA55; tbl[1].data[47:24] = 24'h999999;
        tbl[2].en = 8'h05; tbl[2].ack = 8'h05; tbl[2].spur = 8'h02;
        tbl[2].data[23:0] = 24'h123456; tbl[2].data[71:48] = 24'hABCDEF;
        tbl[3].en = 8'h00; tbl[3].ack = 8'h00;
        tbl[4].en = 8'hA5; tbl[4].ack = 8'hA5; tbl[4].spur = 8'h5A;
        for (int k = 0; k < 8; k++) tbl[4].data[24*k +: 24] = 24'($urandom);
        tbl[5].en = 8'hF0; tbl[5].ack = 8'h70;
        for (int k = 0; k < 8; k++) tbl[5].data[24*k +: 24] = 24'(24'h010101 * (k + 3));

        repeat (2) @(negedge clk);
        check("reset pop_o", 192'(pop_o), 192'(0));
        check("reset frame_data_o", frame_data_o, 192'(0));
        check("reset frame_valid_o", 192'(frame_valid_o), 192'(0));
        check("reset underrun_o", 192'(underrun_o), 192'(0));
        check("reset busy_o", 192'(busy_o), 192'(0));
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // tick during WAIT while ch3 is still outstanding
        @(negedge clk);
        ic = cyc + 1;
        d = '0; d[71:48] = 24'h222222;
        push_exp(8'h0C, 8'h04, d, ic + 3);
        tick_i = 1'b1; ch_en_i = 8'h0C;
        @(negedge clk); tick_i = 1'b0;
        @(negedge clk); ack_i = 8'h04; data_i = 24'h222222;
        @(negedge clk); ack_i = '0; tick_i = 1'b1; ch_en_i = 8'h30;
        d = '0; d[119:96] = 24'h444444; d[143:120] = 24'h555555;
        push_exp(8'h30, 8'h30, d, ic + 7);
        @(negedge clk); tick_i = 1'b0;
        commit_now("tick_in_wait first");
        @(negedge clk);
        check("tick_in_wait reissue pop_o", 192'(pop_o), 192'(8'h30));
        @(negedge clk); ack_i = 8'h10; data_i = 24'h444444;
        @(negedge clk); ack_i = 8'h20; data_i = 24'h555555;
        @(negedge clk); ack_i = '0;
        commit_now("tick_in_wait second");

        // last ack in the same cycle as the next tick
        @(negedge clk);
        ic = cyc + 1;
        d = '0; d[23:0] = 24'h0F0F0F;
        push_exp(8'h01, 8'h01, d, ic + 2);
        tick_i = 1'b1; ch_en_i = 8'h01;
        @(negedge clk); tick_i = 1'b0;
        @(negedge clk); ack_i = 8'h01; data_i = 24'h0F0F0F; tick_i = 1'b1; ch_en_i = 8'h02;
        d = '0; d[47:24] = 24'h5A5A5A;
        push_exp(8'h02, 8'h02, d, ic + 5);
        @(negedge clk); ack_i = '0; tick_i = 1'b0;
        commit_now("ack_with_tick first");
        @(negedge clk);
        check("ack_with_tick reissue pop_o", 192'(pop_o), 192'(8'h02));
        @(negedge clk); ack_i = 8'h02; data_i = 24'h5A5A5A;
        @(negedge clk); ack_i = '0;
        commit_now("ack_with_tick second");

        // tick during ISSUE is held as pending
        @(negedge clk);
        ic = cyc + 1;
        d = '0; d[23:0] = 24'h314159;
        push_exp(8'h01, 8'h01, d, ic + 2);
        tick_i = 1'b1; ch_en_i = 8'h01;
        @(negedge clk); tick_i = 1'b1; ch_en_i = 8'h04;
        @(negedge clk); tick_i = 1'b0; ack_i = 8'h01; data_i = 24'h314159;
        d = '0; d[71:48] = 24'h271828;
        push_exp(8'h04, 8'h04, d, ic + 5);
        @(negedge clk); ack_i = '0;
        commit_now("tick_in_issue first");
        @(negedge clk);
        check("tick_in_issue reissue pop_o", 192'(pop_o), 192'(8'h04));
        @(negedge clk); ack_i = 8'h04; data_i = 24'h271828;
        @(negedge clk); ack_i = '0;
        commit_now("tick_in_issue second");

        // reset in the middle of WAIT
        @(negedge clk);
        tick_i = 1'b1; ch_en_i = 8'hFF;
        @(negedge clk); tick_i = 1'b0;
        @(negedge clk); ack_i = 8'h01; data_i = 24'h777777;
        @(negedge clk); ack_i = '0; rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("midrst pop_o", 192'(pop_o), 192'(0));
        check("midrst frame_data_o", frame_data_o, 192'(0));
        check("midrst frame_valid_o", 192'(frame_valid_o), 192'(0));
        check("midrst underrun_o", 192'(underrun_o), 192'(0));
        check("midrst busy_o", 192'(busy_o), 192'(0));
        prev_frame = '0;
        repeat (2) @(negedge clk);
        check("midrst no late frame_valid_o", 192'(frame_valid_o), 192'(0));
        vclean.en = 8'h81; vclean.ack = 8'h81; vclean.spur = '0; vclean.data = '0;
        vclean.data[23:0] = 24'hC0FFEE; vclean.data[191:168] = 24'hFACADE;
        run_vec(vclean, "post_reset");

        @(negedge clk);
        check("final busy_o", 192'(busy_o), 192'(0));
        check("scoreboard drained", 192'(sb.size()), 192'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
